// File: rtl/cnt_int_pkg.sv
// Shared encodings for the counter-interrupt scheduler (state, vector, irq source codes).
package cnt_int_pkg;

    localparam int unsigned PC_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_COUNTING = 2'd1,
        ST_PENDING  = 2'd2,
        ST_SERVICE  = 2'd3
    } state_e;

    localparam logic [PC_W-1:0] INT_VEC_DEFAULT = 32'h0000_0180;

    localparam logic IRQ_SRC_TIMER = 1'b0;
    localparam logic IRQ_SRC_EXT   = 1'b1;

endpackage

// File: rtl/cnt_int_prescale.sv
// Clock divider: tick_c pulses once every PRESCALE cycles; clr restarts the phase.
module cnt_int_prescale #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick_c
);

    localparam int unsigned PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PS_W-1:0] ps_q;
    logic            wrap;

    assign wrap   = (ps_q == PS_W'(PRESCALE - 1));
    assign tick_c = wrap & ~clr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ps_q <= '0;
        end else if (clr || wrap) begin
            ps_q <= '0;
        end else begin
            ps_q <= ps_q + PS_W'(1);
        end
    end

endmodule

// File: rtl/cnt_int_sched.sv
// Counter interrupt scheduler: down-counter, take-point FSM, epc capture and overrun tracking.
// Optional external interrupt source is enabled with `define CNT_INT_EXT_IRQ_EN.
module cnt_int_sched
    import cnt_int_pkg::*;
#(
    parameter int unsigned     CNT_W    = 32,
    parameter int unsigned     PRESCALE = 1,
    parameter logic [PC_W-1:0] INT_VEC  = INT_VEC_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_we,
    input  logic             cfg_periodic,
    input  logic [CNT_W-1:0] cfg_count,
    input  logic             rti,
    input  logic             stallD,
    input  logic             is_branch_or_jmp_D,
    input  logic             mdrunE,
    input  logic [PC_W-1:0]  pc_resume,
`ifdef CNT_INT_EXT_IRQ_EN
    input  logic             ext_irq,
    output logic             irq_src,
`endif
    output logic             int_en1,
    output logic [PC_W-1:0]  int_vector,
    output logic [PC_W-1:0]  epc,
    output logic             in_service,
    output logic             overrun,
    output logic [CNT_W-1:0] count_out
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_d, reload_q, reload_d;
    logic             periodic_q, periodic_d;
    logic             pend_q, pend_d;
    logic             overrun_d;
    logic             int_d;
    logic [PC_W-1:0]  epc_d;
    logic             tick_c;
    logic             take_c;
    logic             expiry_c;
`ifdef CNT_INT_EXT_IRQ_EN
    logic             src_q, src_d, irq_src_d;
`endif

    cnt_int_prescale #(.PRESCALE(PRESCALE)) u_prescale (
        .clk    (clk),
        .reset  (reset),
        .clr    (cfg_we),
        .tick_c (tick_c)
    );

    assign int_vector = INT_VEC;
    assign take_c     = ~stallD & ~is_branch_or_jmp_D & ~mdrunE;
    assign expiry_c   = tick_c & (count_out == CNT_W'(1));

    // Next-state, counter and capture logic; cfg_we overrides everything else.
    always_comb begin
        state_d    = state_q;
        count_d    = count_out;
        reload_d   = reload_q;
        periodic_d = periodic_q;
        pend_d     = pend_q;
        overrun_d  = overrun;
        int_d      = 1'b0;
        epc_d      = epc;
`ifdef CNT_INT_EXT_IRQ_EN
        src_d      = src_q;
        irq_src_d  = irq_src;
`endif
        if (cfg_we) begin
            count_d    = cfg_count;
            reload_d   = cfg_count;
            periodic_d = cfg_periodic;
            overrun_d  = 1'b0;
            if (state_q != ST_SERVICE) begin
                state_d = (cfg_count == '0) ? ST_IDLE : ST_COUNTING;
            end
        end else begin
            if (tick_c && (count_out != '0)) begin
                count_d = expiry_c ? (periodic_q ? reload_q : '0) : count_out - CNT_W'(1);
            end
            case (state_q)
                ST_IDLE, ST_COUNTING: begin
                    if (expiry_c) begin
                        state_d = ST_PENDING;
`ifdef CNT_INT_EXT_IRQ_EN
                        src_d   = IRQ_SRC_TIMER;
                    end else if (ext_irq) begin
                        state_d = ST_PENDING;
                        src_d   = IRQ_SRC_EXT;
`endif
                    end
                end
                ST_PENDING: begin
                    if (expiry_c) overrun_d = 1'b1;
                    if (take_c) begin
                        int_d   = 1'b1;
                        epc_d   = pc_resume;
                        state_d = ST_SERVICE;
`ifdef CNT_INT_EXT_IRQ_EN
                        irq_src_d = src_q;
`endif
                    end
                end
                ST_SERVICE: begin
                    if (expiry_c) begin
                        overrun_d = 1'b1;
                        pend_d    = 1'b1;
                    end
                    // An expiry landing on the rti cycle is folded into pend_d and re-pends at once.
                    if (rti && !stallD) begin
                        if (pend_d) begin
                            pend_d  = 1'b0;
                            state_d = ST_PENDING;
`ifdef CNT_INT_EXT_IRQ_EN
                            src_d   = IRQ_SRC_TIMER;
`endif
                        end else begin
                            state_d = (count_d != '0) ? ST_COUNTING : ST_IDLE;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            count_out  <= '0;
            reload_q   <= '0;
            periodic_q <= 1'b0;
            pend_q     <= 1'b0;
            overrun    <= 1'b0;
            int_en1    <= 1'b0;
            epc        <= '0;
            in_service <= 1'b0;
`ifdef CNT_INT_EXT_IRQ_EN
            src_q      <= IRQ_SRC_TIMER;
            irq_src    <= IRQ_SRC_TIMER;
`endif
        end else begin
            state_q    <= state_d;
            count_out  <= count_d;
            reload_q   <= reload_d;
            periodic_q <= periodic_d;
            pend_q     <= pend_d;
            overrun    <= overrun_d;
            int_en1    <= int_d;
            epc        <= epc_d;
            in_service <= (state_d == ST_SERVICE);
`ifdef CNT_INT_EXT_IRQ_EN
            src_q      <= src_d;
            irq_src    <= irq_src_d;
`endif
        end
    end

endmodule
